// File: rtl/booth_mult_unit.sv
// booth_mult_unit
//   Sequential radix-2 Booth multiplier for the EX stage. It captures two
//   signed operands on start, runs WIDTH Booth steps, then presents the
//   2*WIDTH-bit product for one DONE cycle. During that cycle it strobes the
//   low word back to the register file. The strobe is suppressed when the
//   destination is register 0.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             multiply request, sampled only in IDLE
//   Operand_A/B       signed multiplicand / multiplier, captured with start
//   Dest_Reg          write-back register index, captured with start
//   busy              high in RUN and DONE (pipeline stall)
//   done              one-cycle result-valid pulse
//   Product_Hi/Lo     product words, held until overwritten
//   RegWrite          register-file write strobe (DONE, Dest_Reg != 0)
//   Write_Reg         captured Dest_Reg
//   Write_Data        equals Product_Lo
module booth_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] Operand_A,
    input  logic [WIDTH-1:0] Operand_B,
    input  logic [4:0]       Dest_Reg,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Product_Hi,
    output logic [WIDTH-1:0] Product_Lo,
    output logic             RegWrite,
    output logic [4:0]       Write_Reg,
    output logic [WIDTH-1:0] Write_Data
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   m_q;      // sign-extended multiplicand
    logic [WIDTH:0]   a_q;      // accumulator, one guard bit so -2^(W-1) works
    logic [WIDTH-1:0] q_q;
    logic             qm1_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   sum;
    logic             last_step;
    logic             busy_d, done_d, rw_d;

    assign last_step  = (cnt_q == CW'(WIDTH - 1));
    assign Write_Data = Product_Lo;

    // Booth recode of {Q[0], Q_-1}
    always_comb begin
        sum = a_q;
        case ({q_q[0], qm1_q})
            2'b01:   sum = a_q + m_q;
            2'b10:   sum = a_q - m_q;
            default: sum = a_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // outputs are registered from the next state so nothing is combinational
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        rw_d   = (state_d == DONE) && (Write_Reg != 5'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            RegWrite <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy     <= busy_d;
            done     <= done_d;
            RegWrite <= rw_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q        <= '0;
            a_q        <= '0;
            q_q        <= '0;
            qm1_q      <= 1'b0;
            cnt_q      <= '0;
            Write_Reg  <= '0;
            Product_Hi <= '0;
            Product_Lo <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        m_q       <= {Operand_A[WIDTH-1], Operand_A};
                        a_q       <= '0;
                        q_q       <= Operand_B;
                        qm1_q     <= 1'b0;
                        cnt_q     <= '0;
                        Write_Reg <= Dest_Reg;
                    end
                end
                RUN: begin
                    // arithmetic shift of {A,Q,Q_-1}, replicating A's sign
                    a_q   <= {sum[WIDTH], sum[WIDTH:1]};
                    q_q   <= {sum[0], q_q[WIDTH-1:1]};
                    qm1_q <= q_q[0];
                    cnt_q <= cnt_q + CW'(1);
                    if (last_step) begin
                        Product_Hi <= sum[WIDTH:1];
                        Product_Lo <= {sum[0], q_q[WIDTH-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_unit.sv
// Self-checking bench for booth_mult_unit: scoreboard of expected products
// filled when a start is driven, drained by a monitor on each done pulse.
module tb_booth_mult_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] opa = '0, opb = '0;
    logic [4:0]  dst = '0;
    logic        busy, done, RegWrite;
    logic [31:0] Product_Hi, Product_Lo, Write_Data;
    logic [4:0]  Write_Reg;

    booth_mult_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .Operand_A(opa), .Operand_B(opb), .Dest_Reg(dst),
        .busy(busy), .done(done),
        .Product_Hi(Product_Hi), .Product_Lo(Product_Lo),
        .RegWrite(RegWrite), .Write_Reg(Write_Reg), .Write_Data(Write_Data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] prod;
        logic        rw;
        logic [4:0]  wr;
    } exp_t;

    exp_t        sbq[$];
    int          dq[$];
    int          n_cmp = 0, n_bad = 0, n_done = 0, n_rw = 0, cyc = 0;
    logic [31:0] rf [32];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (RegWrite) rf[Write_Reg] <= Write_Data;
    end

    always @(negedge clk) begin
        exp_t e;
        if (RegWrite) n_rw++;
        if (rst_n && done) begin
            n_done++;
            dq.push_back(cyc);
            if (sbq.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
            else begin
                e = sbq.pop_front();
                chk("product", {Product_Hi, Product_Lo}, e.prod);
                chk("regwrite", 64'(RegWrite), 64'(e.rw));
                chk("write_reg", 64'(Write_Reg), 64'(e.wr));
                chk("write_data", 64'(Write_Data), 64'(e.prod[31:0]));
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
        exp_t e;
        @(negedge clk);
        opa = a; opb = b; dst = d; start = 1'b1;
        e.prod = model(a, b);
        e.rw   = (d != 5'd0);
        e.wr   = d;
        sbq.push_back(e);
        @(negedge clk);
        // edge 0 has passed; scramble operands to prove they were captured
        start = 1'b0;
        opa = $urandom; opb = $urandom; dst = 5'($urandom);
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
        int k;
        drive(a, b, d);
        k = 1;
        chk("busy_rise", 64'(busy), 64'd1);
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("latency", 64'(k), 64'd33);
        @(negedge clk);
        chk("busy_end", 64'(busy), 64'd0);
        chk("done_end", 64'(done), 64'd0);
    endtask

    initial begin
        int k, d0, r0;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rw", 64'(RegWrite), 64'd0);
        chk("rst_prod", {Product_Hi, Product_Lo}, 64'd0);
        chk("rst_wreg", 64'(Write_Reg), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic and sign / corner cases
        run_mul(32'd3, 32'd5, 5'd8);
        chk("rf8", 64'(rf[8]), 64'd15);
        run_mul(32'hFFFF_FFF9, 32'd6, 5'd1);
        run_mul(32'd6, 32'hFFFF_FFF9, 5'd2);
        run_mul(32'h8000_0000, 32'h8000_0000, 5'd3);
        run_mul(32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
        run_mul(32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd5);
        run_mul(32'h1234_5678, 32'h9ABC_DEF0, 5'd31);
        chk("const_mixed", 64'h0000_0000_FFFF_FFD6 | 64'hFFFF_FFFF_0000_0000, model(32'hFFFF_FFF9, 32'd6));

        // start pulses during RUN and DONE are ignored
        d0 = n_done;
        drive(32'd2, 32'd2, 5'd6);
        k = 1;
        while (k < 40) begin
            start = (k == 10 || k == 33);
            if (start) begin opa = 32'd9; opb = 32'd9; end
            if (k == 33) begin
                chk("ign_busy33", 64'(busy), 64'd1);
                chk("ign_done33", 64'(done), 64'd1);
            end
            if (k == 34) chk("ign_busy34", 64'(busy), 64'd0);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk("ign_ndone", 64'(n_done - d0), 64'd1);
        chk("ign_busy_after", 64'(busy), 64'd0);

        // asynchronous reset mid-run
        drive(32'd5, 32'd5, 5'd7);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_done", 64'(done), 64'd0);
        chk("mid_rw", 64'(RegWrite), 64'd0);
        chk("mid_prod", {Product_Hi, Product_Lo}, 64'd0);
        chk("mid_wdata", 64'(Write_Data), 64'd0);
        chk("mid_wreg", 64'(Write_Reg), 64'd0);
        sbq.delete();
        d0 = n_done;
        r0 = n_rw;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("mid_no_done", 64'(n_done - d0), 64'd0);
        chk("mid_no_rw", 64'(n_rw - r0), 64'd0);
        run_mul(32'd4, 32'd4, 5'd9);
        chk("rf9", 64'(rf[9]), 64'd16);

        // destination zero suppresses the write strobe
        r0 = n_rw;
        run_mul(32'd10, 32'd10, 5'd0);
        chk("dst0_no_rw", 64'(n_rw - r0), 64'd0);

        // start held high: a new multiply every 34 cycles
        dq.delete();
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.prod = model(32'd7, 32'hFFFF_FFFD);
            e.rw   = 1'b1;
            e.wr   = 5'd5;
            sbq.push_back(e);
        end
        @(negedge clk);
        opa = 32'd7; opb = 32'hFFFF_FFFD; dst = 5'd5; start = 1'b1;
        repeat (70) @(negedge clk);
        start = 1'b0;
        repeat (45) @(negedge clk);
        chk("b2b_count", 64'(dq.size()), 64'd3);
        if (dq.size() == 3) begin
            chk("b2b_gap1", 64'(dq[1] - dq[0]), 64'd34);
            chk("b2b_gap2", 64'(dq[2] - dq[1]), 64'd34);
        end

        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
